// File: rtl/simon_pkg.sv
// Shared constants and the controller state type for the SIMON pipeline control.
package simon_pkg;

    localparam int SIMON_ROUNDS = 32;
    // 32 round registers plus the ciphertext register
    localparam int PIPE_DEPTH   = SIMON_ROUNDS + 1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_KEY_WAIT = 2'd1,
        ST_RUN      = 2'd2,
        ST_DRAIN    = 2'd3
    } simon_ctrl_state_t;

endpackage

// File: rtl/simon_valid_pipe.sv
// Enable-gated valid/tag shift register that shadows the round pipeline.
// Valid bits are reset; tags are plain data and are not.
module simon_valid_pipe #(
    parameter int TAG_W = 4,
    parameter int DEPTH = 33
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_vld,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_vld,
    output logic [TAG_W-1:0] o_tag
);

    logic [DEPTH-1:0] r_vld;
    logic [TAG_W-1:0] r_tag [DEPTH];

    // Valid bits shift one place per advance; cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= '0;
        end else if (i_en) begin
            r_vld <= {r_vld[DEPTH-2:0], i_vld};
        end
    end

    // Tags follow the valid bits on every advance.
    always_ff @(posedge clk) begin
        if (i_en) begin
            r_tag[0] <= i_tag;
            for (int i = 1; i < DEPTH; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    assign o_vld = r_vld[DEPTH-1];
    assign o_tag = r_tag[DEPTH-1];

endmodule

// File: rtl/simon_pipe_ctrl.sv
// Control for a 32-round SIMON pipeline: key loading, request flow,
// back-pressure from the ciphertext consumer, and drain before rekeying.
// Optional macro SIMON_CTRL_STATS_EN adds the blk_count pop counter.
module simon_pipe_ctrl
    import simon_pkg::*;
#(
    parameter int TAG_W   = 4,
    parameter int KEY_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [TAG_W-1:0] in_tag,
    output logic             in_ready,
    input  logic             key_valid,
    output logic             key_ready,
    output logic             key_load,
    output logic             advance,
    output logic             ct_valid,
    output logic [TAG_W-1:0] ct_tag,
    input  logic             ct_ready,
    output logic             busy
`ifdef SIMON_CTRL_STATS_EN
    ,output logic [15:0]     blk_count
`endif
);

    localparam int CNT_W = (KEY_LAT > 1) ? $clog2(KEY_LAT) : 1;
    // The handshake cycle is the first of the KEY_LAT cycles, so KEY_WAIT
    // lasts KEY_LAT-1 cycles and RUN starts exactly KEY_LAT cycles later.
    localparam logic [CNT_W-1:0] KEY_CNT_INIT = CNT_W'((KEY_LAT > 1) ? KEY_LAT - 1 : 0);
    localparam simon_ctrl_state_t KEY_NEXT = (KEY_LAT > 1) ? ST_KEY_WAIT : ST_RUN;

    simon_ctrl_state_t r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [5:0]        r_occ;

    logic             w_ct_vld;
    logic [TAG_W-1:0] w_ct_tag;
    logic             w_stall;
    logic             w_adv;
    logic             w_in_rdy;
    logic             w_key_rdy;
    logic             w_key_hs;
    logic             w_push;
    logic             w_pop;

    simon_valid_pipe #(
        .TAG_W (TAG_W),
        .DEPTH (PIPE_DEPTH)
    ) u_valid_pipe (
        .clk   (clk),
        .rst   (rst),
        .i_en  (w_adv),
        .i_vld (w_push),
        .i_tag (in_tag),
        .o_vld (w_ct_vld),
        .o_tag (w_ct_tag)
    );

    // Handshake qualifiers per state; everything forced low while in reset.
    always_comb begin
        w_stall   = w_ct_vld && !ct_ready;
        w_adv     = 1'b0;
        w_in_rdy  = 1'b0;
        w_key_rdy = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_key_rdy = 1'b1;
            end
            ST_RUN: begin
                w_adv     = !w_stall;
                w_in_rdy  = !w_stall && !key_valid;
                w_key_rdy = (r_occ == 6'd0);
            end
            ST_DRAIN: begin
                w_adv     = !w_stall;
                w_key_rdy = (r_occ == 6'd0);
            end
            default: begin
                w_adv     = 1'b0;
            end
        endcase
        if (rst) begin
            w_adv     = 1'b0;
            w_in_rdy  = 1'b0;
            w_key_rdy = 1'b0;
        end
    end

    assign w_key_hs = key_valid && w_key_rdy;
    assign w_push   = in_valid && w_in_rdy;
    assign w_pop    = w_ct_vld && ct_ready && w_adv;

    // Controller state machine and key-schedule settle counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_key_hs) begin
                        r_state <= KEY_NEXT;
                        r_cnt   <= KEY_CNT_INIT;
                    end
                end
                ST_KEY_WAIT: begin
                    if (r_cnt <= CNT_W'(1)) begin
                        r_state <= ST_RUN;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    if (w_key_hs) begin
                        r_state <= KEY_NEXT;
                        r_cnt   <= KEY_CNT_INIT;
                    end else if (key_valid) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_key_hs) begin
                        r_state <= KEY_NEXT;
                        r_cnt   <= KEY_CNT_INIT;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Blocks in flight: +1 on accept, -1 on pop, both cancel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_occ <= 6'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + 6'd1;
                2'b01:   r_occ <= r_occ - 6'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

`ifdef SIMON_CTRL_STATS_EN
    logic [15:0] r_blk_count;

    // Count emitted blocks, wrapping naturally at 16 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_blk_count <= 16'd0;
        end else if (w_pop) begin
            r_blk_count <= r_blk_count + 16'd1;
        end
    end

    assign blk_count = r_blk_count;
`endif

    assign in_ready  = w_in_rdy;
    assign key_ready = w_key_rdy;
    assign key_load  = w_key_hs;
    assign advance   = w_adv;
    assign ct_valid  = w_ct_vld && !rst;
    assign ct_tag    = rst ? '0 : w_ct_tag;
    assign busy      = !rst && ((r_state != ST_IDLE) || (r_occ != 6'd0));

endmodule

// File: tb/tb_simon_pipe_ctrl.sv
// Randomized bench for simon_pipe_ctrl against a block-age reference model.
module tb_simon_pipe_ctrl;

    localparam int TAG_W   = 4;
    localparam int KEY_LAT = 2;
    localparam int M_IDLE = 0, M_KW = 1, M_RUN = 2, M_DRAIN = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             in_ready;
    logic             key_valid = 1'b0;
    logic             key_ready;
    logic             key_load;
    logic             advance;
    logic             ct_valid;
    logic [TAG_W-1:0] ct_tag;
    logic             ct_ready = 1'b0;
    logic             busy;
`ifdef SIMON_CTRL_STATS_EN
    logic [15:0]      blk_count;
`endif

    simon_pipe_ctrl #(.TAG_W(TAG_W), .KEY_LAT(KEY_LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_tag    (in_tag),
        .in_ready  (in_ready),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_load  (key_load),
        .advance   (advance),
        .ct_valid  (ct_valid),
        .ct_tag    (ct_tag),
        .ct_ready  (ct_ready),
        .busy      (busy)
`ifdef SIMON_CTRL_STATS_EN
        ,.blk_count (blk_count)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: in-flight blocks as (tag, advances since accept).
    int m_tag[$];
    int m_age[$];
    int mode     = M_IDLE;
    int key_cyc  = 0;
    int cyc      = 0;
    int m_pops   = 0;
    bit m_pushed = 1'b0;
    bit m_kload  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_in_ready"}, in_ready, 0);
        chk({pfx, "_key_ready"}, key_ready, 0);
        chk({pfx, "_key_load"}, key_load, 0);
        chk({pfx, "_advance"}, advance, 0);
        chk({pfx, "_ct_valid"}, ct_valid, 0);
        chk({pfx, "_ct_tag"}, ct_tag, 0);
        chk({pfx, "_busy"}, busy, 0);
`ifdef SIMON_CTRL_STATS_EN
        chk({pfx, "_blk_count"}, blk_count, 0);
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_all_zero("rst_now");
        @(negedge clk);
        #1;
        chk_all_zero("rst_hold");
        rst = 1'b0;
        m_tag.delete();
        m_age.delete();
        mode   = M_IDLE;
        m_pops = 0;
    endtask

    // One clock cycle: drive, compare against the model, advance the model.
    task automatic run_cyc(input logic iv, input logic [TAG_W-1:0] tg, input logic kv, input logic cr);
        int occ;
        bit e_ctv, stall, e_adv, e_ir, e_kr, e_kl, e_busy;
        @(negedge clk);
        in_valid = iv; in_tag = tg; key_valid = kv; ct_ready = cr;
        #1;
        occ    = m_tag.size();
        e_ctv  = (occ > 0) && (m_age[0] == 33);
        stall  = e_ctv && !cr;
        e_adv  = 1'b0; e_ir = 1'b0; e_kr = 1'b0;
        if (mode == M_IDLE) begin
            e_kr = 1'b1;
        end else if (mode == M_RUN) begin
            e_adv = !stall; e_ir = !stall && !kv; e_kr = (occ == 0);
        end else if (mode == M_DRAIN) begin
            e_adv = !stall; e_kr = (occ == 0);
        end
        e_kl   = kv && e_kr;
        e_busy = (mode != M_IDLE) || (occ != 0);
        chk("ct_valid", ct_valid, e_ctv);
        if (e_ctv) chk("ct_tag", ct_tag, m_tag[0]);
        chk("advance", advance, e_adv);
        chk("in_ready", in_ready, e_ir);
        chk("key_ready", key_ready, e_kr);
        chk("key_load", key_load, e_kl);
        chk("busy", busy, e_busy);
`ifdef SIMON_CTRL_STATS_EN
        chk("blk_count", blk_count, m_pops & 32'hFFFF);
`endif
        m_pushed = 1'b0;
        m_kload  = e_kl;
        if (e_ctv && cr) begin
            void'(m_tag.pop_front());
            void'(m_age.pop_front());
            m_pops++;
        end
        if (e_adv) foreach (m_age[i]) m_age[i]++;
        if (iv && e_ir) begin
            m_tag.push_back(int'(tg));
            m_age.push_back(1);
            m_pushed = 1'b1;
        end
        if (e_kl) begin
            key_cyc = cyc;
            mode = (KEY_LAT <= 1) ? M_RUN : M_KW;
        end else if (mode == M_KW && (cyc + 1 - key_cyc) >= KEY_LAT) begin
            mode = M_RUN;
        end else if (mode == M_RUN && kv && occ != 0) begin
            mode = M_DRAIN;
        end
        cyc++;
    endtask

    task automatic load_key();
        int n = 0;
        do begin
            run_cyc(1'b0, '0, 1'b1, 1'b1);
            n++;
        end while (!m_kload && n < 100);
        if (!m_kload) chk("key_timeout", 0, 1);
    endtask

    task automatic flush();
        int n = 0;
        while (m_tag.size() != 0 && n < 200) begin
            run_cyc(1'b0, '0, 1'b0, 1'b1);
            n++;
        end
        if (m_tag.size() != 0) chk("flush_timeout", 0, 1);
    endtask

    initial begin
        int n;
        logic [TAG_W-1:0] tg;

        // Reset and power-on state
        do_reset();

        // Single block: key, then tag 3; accept 2 cycles after handshake, out 33 later
        load_key();
        n = 0;
        do begin
            run_cyc(1'b1, 4'd3, 1'b0, 1'b1);
            n++;
        end while (!m_pushed && n < 10);
        chk("accept_delay", n, KEY_LAT);
        n = 0;
        do begin
            run_cyc(1'b0, '0, 1'b0, 1'b1);
            n++;
        end while (!ct_valid && n < 60);
        chk("latency", n, 33);
        chk("first_tag", ct_tag, 3);
        flush();

        // 40 back-to-back requests, tags wrapping
        for (int i = 0; i < 40; i++) run_cyc(1'b1, TAG_W'(i % 16), 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) run_cyc(1'b0, '0, 1'b0, 1'b1);

        // Fill under back-pressure, hold 10 stalled cycles, release
        for (int i = 0; i < 50; i++) run_cyc(1'b1, TAG_W'($urandom_range(15)), 1'b0, 1'b0);
        chk("full_busy", busy, 1);
        for (int i = 0; i < 10; i++) run_cyc(1'b1, TAG_W'($urandom_range(15)), 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) run_cyc(1'b1, TAG_W'($urandom_range(15)), 1'b0, 1'b1);
        flush();

        // Random traffic with random back-pressure
        for (int i = 0; i < 300; i++) begin
            tg = TAG_W'($urandom_range(15));
            run_cyc($urandom_range(3) != 0, tg, 1'b0, $urandom_range(9) < 7);
        end
        flush();

        // Rekey with 5 blocks in flight: drain, then KEY_WAIT, then RUN
        for (int i = 0; i < 5; i++) run_cyc(1'b1, TAG_W'(i + 9), 1'b0, 1'b1);
        load_key();
        for (int i = 0; i < 4; i++) run_cyc(1'b1, TAG_W'(i), 1'b0, 1'b1);

        // Reset mid-stream with 20 in flight; nothing emerges without a new key
        for (int i = 0; i < 20; i++) run_cyc(1'b1, TAG_W'(i), 1'b0, 1'b1);
        do_reset();
        for (int i = 0; i < 40; i++) run_cyc(1'b1, TAG_W'(i), 1'b0, 1'b1);
        load_key();

        // Random traffic including occasional rekey requests
        for (int i = 0; i < 600; i++) begin
            tg = TAG_W'($urandom_range(15));
            run_cyc($urandom_range(3) != 0, tg, $urandom_range(40) == 0, $urandom_range(9) < 8);
        end

`ifdef SIMON_CTRL_STATS_EN
        // Pop counter wrap: 65537 pops leave blk_count at 1
        do_reset();
        load_key();
        n = 0;
        while (m_pops < 65537 && n < 70000) begin
            run_cyc(1'b1, TAG_W'(n), 1'b0, 1'b1);
            n++;
        end
        chk("blk_wrap", blk_count, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
